// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants, capture FSM states, pixel type and the
// CRC-16-CCITT step used by the optional frame checksum.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_SKIP   = 144;
  localparam int V_ACTIVE = 480;
  localparam int V_SKIP   = 35;

  typedef logic [23:0] rgb_t;

  typedef enum logic [2:0] {
    IDLE,
    VSKIP,
    HSKIP,
    ACTIVE,
    LINE_END,
    DONE
  } cap_state_t;

  // CRC-16-CCITT (poly 0x1021), one 24-bit pixel per call, MSB first
  function automatic logic [15:0] crc16_px(input logic [15:0] crc, input rgb_t px);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      fb = c[15] ^ px[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
endpackage

// File: rtl/vga_frame_capture_sync_edge.sv
// vga_sync_edge: registers hsync/vsync on each pixel strobe and flags falling
// edges in the strobe cycle where the low level is first seen.
module vga_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pix_en,
  input  logic hsync,
  input  logic vsync,
  output logic hsync_fall,
  output logic vsync_fall
);
  logic hs_q, vs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else if (pix_en) begin
      hs_q <= hsync;
      vs_q <= vsync;
    end
  end

  assign hsync_fall = pix_en & hs_q & ~hsync;
  assign vsync_fall = pix_en & vs_q & ~vsync;
endmodule

// File: rtl/vga_frame_capture.sv
// vga_frame_capture: VGA sink that recovers line/column from sync edges and
// writes visible pixels to a frame-buffer port. VGA_CAPTURE_CRC_EN adds frame_crc.
module vga_frame_capture #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_SKIP   = vga_pkg::H_SKIP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_SKIP   = vga_pkg::V_SKIP,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic              capture_en,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [23:0]       rgb_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic              line_err,
  output logic              frame_err
`ifdef VGA_CAPTURE_CRC_EN
  ,
  output logic [15:0]       frame_crc
`endif
);
  import vga_pkg::*;

  localparam int CNT_MAX = (H_SKIP > H_ACTIVE) ? ((H_SKIP > V_SKIP) ? H_SKIP : V_SKIP)
                                               : ((H_ACTIVE > V_SKIP) ? H_ACTIVE : V_SKIP);
  localparam int CNT_W  = $clog2(CNT_MAX + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam logic [CNT_W-1:0]  HS_LAST  = CNT_W'(H_SKIP - 1);
  localparam logic [CNT_W-1:0]  VS_LAST  = CNT_W'(V_SKIP - 1);
  localparam logic [CNT_W-1:0]  COL_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [LINE_W-1:0] LINES    = LINE_W'(V_ACTIVE);

  cap_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, col;
  logic [LINE_W-1:0] line_cnt, line_n;
  logic [ADDR_W-1:0] addr, addr_n, base, base_n;
  logic              wr_n, line_err_n, frame_err_n, restart;
  logic              hsync_fall, vsync_fall;

  vga_sync_edge u_edge (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .hsync_fall (hsync_fall),
    .vsync_fall (vsync_fall)
  );

  // cnt counts hsync falls in VSKIP, strobes in HSKIP and pixels in ACTIVE
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    line_n      = line_cnt;
    addr_n      = addr;
    base_n      = base;
    wr_n        = 1'b0;
    line_err_n  = line_err;
    frame_err_n = frame_err;
    restart     = 1'b0;
    col         = (state == HSKIP) ? '0 : cnt;
    case (state)
      IDLE:   if (vsync_fall && capture_en) restart = 1'b1;
      VSKIP:  if (hsync_fall) begin
                if (cnt == VS_LAST) begin
                  state_n = HSKIP;
                  cnt_n   = '0;
                end else cnt_n = cnt + CNT_W'(1);
              end
      HSKIP:  if (hsync_fall) cnt_n = '0;
              else if (pix_en) begin
                if (cnt == HS_LAST) wr_n = 1'b1;
                else cnt_n = cnt + CNT_W'(1);
              end
      ACTIVE: if (hsync_fall) begin
                // short line: skip to the next line start; a short last line ends the frame
                line_err_n = 1'b1;
                line_n     = line_cnt + LINE_W'(1);
                base_n     = base + ADDR_W'(H_ACTIVE);
                addr_n     = base_n;
                cnt_n      = '0;
                state_n    = (line_n == LINES) ? DONE : HSKIP;
              end else if (pix_en) wr_n = 1'b1;
      LINE_END: if (hsync_fall) begin
                cnt_n   = '0;
                state_n = (line_cnt == LINES) ? DONE : HSKIP;
              end
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (wr_n) begin
      addr_n = addr + ADDR_W'(1);
      if (col == COL_LAST) begin
        state_n = LINE_END;
        line_n  = line_cnt + LINE_W'(1);
        base_n  = base + ADDR_W'(H_ACTIVE);
      end else begin
        state_n = ACTIVE;
        cnt_n   = col + CNT_W'(1);
      end
    end
    if (vsync_fall && state != IDLE && state != DONE) begin
      frame_err_n = 1'b1;
      wr_n        = 1'b0;
      if (capture_en) restart = 1'b1;
      else state_n = IDLE;
    end
    if (restart) begin
      state_n = VSKIP;
      cnt_n   = '0;
      line_n  = '0;
      addr_n  = '0;
      base_n  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      line_cnt  <= '0;
      addr      <= '0;
      base      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      line_cnt  <= line_n;
      addr      <= addr_n;
      base      <= base_n;
      wr_en     <= wr_n;
      line_err  <= line_err_n;
      frame_err <= frame_err_n;
      if (wr_n) begin
        wr_addr <= addr;
        wr_data <= rgb_in;
      end
    end
  end

  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE) && (state != DONE);

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc_run;

  // frame_crc updates on the edge that raises frame_done, so both are valid together
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_run   <= 16'hFFFF;
      frame_crc <= 16'hFFFF;
    end else begin
      if (restart) crc_run <= 16'hFFFF;
      else if (wr_n) crc_run <= crc16_px(crc_run, rgb_in);
      if (state_n == DONE && state != DONE) frame_crc <= crc_run;
    end
  end
`endif
endmodule

// File: tb/tb_vga_frame_capture.sv
// Randomized bench for vga_frame_capture with small timing; the frame generator
// predicts every write from pixel position, plus frame_done count and error flags.
module tb_vga_frame_capture;
  localparam int HA = 4, HS = 3, VA = 2, VS = 1, AW = 4;
  localparam int LINE_LEN = HS + HA + 1;

  logic          clk = 1'b0;
  logic          reset, pix_en, capture_en, hsync, vsync;
  logic [23:0]   rgb_in, wr_data;
  logic          wr_en, frame_done, busy, line_err, frame_err;
  logic [AW-1:0] wr_addr;
`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0]   frame_crc;
  logic [15:0]   crc_acc;
  logic [15:0]   crc_q[$];
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [23:0]   d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0, n_bad = 0;
  int  done_seen = 0, done_exp = 0;

  always #5 clk = ~clk;

  vga_frame_capture #(
    .H_ACTIVE(HA), .H_SKIP(HS), .V_ACTIVE(VA), .V_SKIP(VS), .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .capture_en (capture_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb_in     (rgb_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .busy       (busy),
    .line_err   (line_err),
    .frame_err  (frame_err)
`ifdef VGA_CAPTURE_CRC_EN
    ,
    .frame_crc  (frame_crc)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

`ifdef VGA_CAPTURE_CRC_EN
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [23:0] d);
    int r;
    r = int'(c);
    for (int i = 23; i >= 0; i--) begin
      r = r ^ (int'(d[i]) << 15);
      r = r << 1;
      if ((r & 'h10000) != 0) r = r ^ 'h11021;
    end
    return r[15:0];
  endfunction
`endif

  function automatic logic [23:0] pix(input int mode, input int idx);
    case (mode)
      1:       return 24'(idx);
      2:       return 24'h0;
      default: return 24'($urandom);
    endcase
  endfunction

  // write and frame_done monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(mon_e.a));
          check("wr_data", 32'(wr_data), 32'(mon_e.d));
        end else check("wr_unexpected", 32'(wr_en), 32'd0);
      end
      if (frame_done) begin
        done_seen++;
`ifdef VGA_CAPTURE_CRC_EN
        if (crc_q.size() > 0) check("frame_crc", 32'(frame_crc), 32'(crc_q.pop_front()));
        else check("crc_unexpected", 32'(frame_done), 32'd0);
`endif
      end
    end
  end

  task automatic tick(input logic h, input logic v, input logic [23:0] d);
    @(negedge clk);
    hsync = h; vsync = v; rgb_in = d; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic blank_line();
    for (int s = 0; s < LINE_LEN; s++) tick(s < 2 ? 1'b0 : 1'b1, 1'b1, 24'($urandom));
  endtask

  task automatic tail();
    blank_line();
    repeat (3) @(negedge clk);
  endtask

  // vsync line (vsync falls on strobe 2), VS-1 blank lines, then VA visible lines
  task automatic frame(input int mode, input int short_line, input int short_npix,
                       input bit abort0, input bit drop);
    bit          cap = 1'b0;
    int          n, len, col;
    logic [23:0] d;
    wr_t         we;
    for (int s = 0; s < LINE_LEN; s++) begin
      if (s == 2) begin
        cap = capture_en;
`ifdef VGA_CAPTURE_CRC_EN
        crc_acc = 16'hFFFF;
`endif
      end
      tick(s < 2 ? 1'b0 : 1'b1, s < 2 ? 1'b1 : 1'b0, 24'($urandom));
    end
    check("busy_at_start", 32'(busy), 32'(cap));
    if (drop) capture_en = 1'b0;
    for (int b = 1; b < VS; b++) blank_line();
    for (int l = 0; l < VA; l++) begin
      n   = (l == short_line) ? short_npix : HA;
      len = HS + n + ((n == HA) ? 1 + int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < len; s++) begin
        col = s - HS;
        d   = (col >= 0 && col < n) ? pix(mode, l * HA + col) : 24'($urandom);
        if (cap && col >= 0 && col < n) begin
          we.a = AW'(l * HA + col);
          we.d = d;
          exp_q.push_back(we);
`ifdef VGA_CAPTURE_CRC_EN
          crc_acc = crc_model(crc_acc, d);
`endif
        end
        tick(s < 2 ? 1'b0 : 1'b1, 1'b1, d);
      end
      if (abort0) return;
    end
    if (cap) begin
      done_exp++;
`ifdef VGA_CAPTURE_CRC_EN
      crc_q.push_back(crc_acc);
`endif
    end
  endtask

  task automatic end_checks(input string tag, input bit le, input bit fe);
    check({tag, "_done"}, 32'(done_seen), 32'(done_exp));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_line_err"}, 32'(line_err), 32'(le));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(fe));
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int sl;
    reset = 1'b1; pix_en = 1'b0; capture_en = 1'b0;
    hsync = 1'b1; vsync = 1'b1; rgb_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_line_err", 32'(line_err), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
`ifdef VGA_CAPTURE_CRC_EN
    check("rst_frame_crc", 32'(frame_crc), 32'hFFFF);
`endif

    // clean frames: index data, random data, two all-zero frames
    capture_en = 1'b1;
    frame(1, -1, 0, 1'b0, 1'b0);
    frame(0, -1, 0, 1'b0, 1'b0);
    frame(2, -1, 0, 1'b0, 1'b0);
    frame(2, -1, 0, 1'b0, 1'b0);
    tail();
    end_checks("clean", 1'b0, 1'b0);

    // capture_en dropped during a frame: that frame completes, next one is ignored
    frame(0, -1, 0, 1'b0, 1'b1);
    frame(0, -1, 0, 1'b0, 1'b0);
    tail();
    end_checks("drop", 1'b0, 1'b0);

    // early hsync after 2 pixels on line 0
    do_reset();
    capture_en = 1'b1;
    frame(0, 0, 2, 1'b0, 1'b0);
    tail();
    end_checks("short", 1'b1, 1'b0);

    // vsync after line 0 aborts, the same edge starts the next frame
    do_reset();
    frame(0, -1, 0, 1'b1, 1'b0);
    frame(1, -1, 0, 1'b0, 1'b0);
    tail();
    end_checks("abort", 1'b0, 1'b1);

    // random mix of clean and short-line frames
    do_reset();
    for (int k = 0; k < 6; k++) begin
      sl = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, VA - 2));
      frame(0, sl, int'($urandom_range(1, HA - 1)), 1'b0, 1'b0);
    end
    tail();
    check("rand_done", 32'(done_seen), 32'(done_exp));
    check("rand_pending", 32'(exp_q.size()), 32'd0);
    check("rand_frame_err", 32'(frame_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
